// File: rtl/macroblock_tiler_if.sv
`default_nettype none
// ============================================================================
// Module      : macroblock_tiler_if
// Description : Pixel stream bundle for the macroblock tiler. The raster input
//               handshake, the tiled output handshake and the output sideband
//               tags. "slave" is the tiler side, "master" is the source/sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface macroblock_tiler_if #(
  parameter int PIXEL_WIDTH  = 24,
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 240,
  parameter int MB_SIZE      = 16
);
  localparam int c_MBX_W = ($clog2(FRAME_WIDTH / MB_SIZE) < 1) ? 1 : $clog2(FRAME_WIDTH / MB_SIZE);
  localparam int c_MBY_W = ($clog2(FRAME_HEIGHT / MB_SIZE) < 1) ? 1 : $clog2(FRAME_HEIGHT / MB_SIZE);

  logic                   valid_in;
  logic                   ready_in;
  logic [PIXEL_WIDTH-1:0] pixel_in;
  logic                   valid_out;
  logic                   ready_out;
  logic [PIXEL_WIDTH-1:0] pixel_out;
  logic [c_MBX_W-1:0]     mb_x;
  logic [c_MBY_W-1:0]     mb_y;
  logic                   first_out;
  logic                   last_out;
  logic                   frame_end;

  modport slave (
    input  valid_in, pixel_in, ready_out,
    output ready_in, valid_out, pixel_out, mb_x, mb_y, first_out, last_out, frame_end
  );

  modport master (
    output valid_in, pixel_in, ready_out,
    input  ready_in, valid_out, pixel_out, mb_x, mb_y, first_out, last_out, frame_end
  );
endinterface
`default_nettype wire

// File: rtl/macroblock_tiler.sv
`default_nettype none
// ============================================================================
// Module      : macroblock_tiler
// Description : Raster-to-macroblock reorder. Two ping-pong band buffers, each
//               MB_SIZE lines tall, are filled in raster order and read out one
//               macroblock at a time through a two-stage (read + output) pipe
//               that absorbs the one-cycle memory latency without bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module macroblock_tiler #(
  parameter int PIXEL_WIDTH  = 24,
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 240,
  parameter int MB_SIZE      = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  macroblock_tiler_if.slave bus
);

  localparam int c_NMBX  = FRAME_WIDTH / MB_SIZE;
  localparam int c_NMBY  = FRAME_HEIGHT / MB_SIZE;
  localparam int c_DEPTH = MB_SIZE * FRAME_WIDTH;
  localparam int c_AW    = ($clog2(c_DEPTH) < 1) ? 1 : $clog2(c_DEPTH);
  localparam int c_MBW   = ($clog2(MB_SIZE) < 1) ? 1 : $clog2(MB_SIZE);
  localparam int c_MBX_W = ($clog2(c_NMBX) < 1) ? 1 : $clog2(c_NMBX);
  localparam int c_MBY_W = ($clog2(c_NMBY) < 1) ? 1 : $clog2(c_NMBY);

  // A band must be deeper than the read pipe, otherwise the read pointer could
  // lap a bank whose last pixel is still waiting in the output register.
  generate
    if ((FRAME_WIDTH % MB_SIZE) != 0 || (FRAME_HEIGHT % MB_SIZE) != 0) begin : g_bad_geometry
      $error("macroblock_tiler: frame dimensions must be multiples of MB_SIZE");
    end
    if (c_DEPTH < 4) begin : g_band_too_small
      $error("macroblock_tiler: band buffer must hold at least 4 pixels");
    end
  endgenerate

  // Band storage, bank index first
  logic [PIXEL_WIDTH-1:0] r_mem [2][c_DEPTH];

  // Write side
  logic            r_wbank;
  logic [c_AW-1:0] r_waddr;
  logic [1:0]      r_full;

  // Read-issue side: position of the next pixel to fetch
  logic               r_ibank;
  logic [c_MBW-1:0]   r_icol;
  logic [c_MBW-1:0]   r_irow;
  logic [c_MBX_W-1:0] r_imb;
  logic [c_MBY_W-1:0] r_iband;

  // Bank whose last pixel has yet to leave the output register
  logic r_dbank;

  // Stage A: memory read data plus its tags
  logic                   r_a_valid;
  logic [PIXEL_WIDTH-1:0] r_a_data;
  logic [c_MBX_W-1:0]     r_a_mbx;
  logic [c_MBY_W-1:0]     r_a_mby;
  logic                   r_a_first;
  logic                   r_a_last;
  logic                   r_a_bend;
  logic                   r_a_fend;

  // Stage B: the registered output
  logic                   r_b_valid;
  logic [PIXEL_WIDTH-1:0] r_b_pix;
  logic [c_MBX_W-1:0]     r_b_mbx;
  logic [c_MBY_W-1:0]     r_b_mby;
  logic                   r_b_first;
  logic                   r_b_last;
  logic                   r_b_bend;
  logic                   r_b_fend;

  logic            w_ready_in;
  logic            w_accept;
  logic            w_fill;
  logic            w_b_ready;
  logic            w_a_ready;
  logic            w_issue;
  logic            w_drain;
  logic [c_AW-1:0] w_raddr;
  logic            w_i_rowend;
  logic            w_i_mbend;
  logic            w_i_bend;

  assign w_ready_in = !rst && !r_full[r_wbank];
  assign w_accept   = bus.valid_in && w_ready_in;
  assign w_fill     = w_accept && (r_waddr == c_AW'(c_DEPTH - 1));

  // Output register frees on handshake; stage A frees when it can move to B
  assign w_b_ready = !r_b_valid || bus.ready_out;
  assign w_a_ready = !r_a_valid || w_b_ready;
  assign w_issue   = r_full[r_ibank] && w_a_ready;
  assign w_drain   = r_b_valid && bus.ready_out && r_b_bend;

  assign w_raddr    = c_AW'(int'(r_irow) * FRAME_WIDTH + int'(r_imb) * MB_SIZE + int'(r_icol));
  assign w_i_rowend = (r_icol == c_MBW'(MB_SIZE - 1));
  assign w_i_mbend  = w_i_rowend && (r_irow == c_MBW'(MB_SIZE - 1));
  assign w_i_bend   = w_i_mbend && (r_imb == c_MBX_W'(c_NMBX - 1));

  // Band memory: raster writes and registered macroblock-order reads
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wbank][r_waddr] <= bus.pixel_in;
    end
    if (w_issue) begin
      r_a_data <= r_mem[r_ibank][w_raddr];
    end
  end

  // Raster write pointer; hops to the other bank once a band is complete
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waddr <= '0;
      r_wbank <= 1'b0;
    end else if (w_accept) begin
      if (w_fill) begin
        r_waddr <= '0;
        r_wbank <= ~r_wbank;
      end else begin
        r_waddr <= r_waddr + c_AW'(1);
      end
    end
  end

  // Full flags: fill and drain always target different banks, so both apply
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full  <= '0;
      r_dbank <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_fill && (r_wbank == 1'(i))) begin
          r_full[i] <= 1'b1;
        end else if (w_drain && (r_dbank == 1'(i))) begin
          r_full[i] <= 1'b0;
        end
      end
      if (w_drain) begin
        r_dbank <= ~r_dbank;
      end
    end
  end

  // Read-issue counters: column within row, row within MB, MB within band
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ibank <= 1'b0;
      r_icol  <= '0;
      r_irow  <= '0;
      r_imb   <= '0;
      r_iband <= '0;
    end else if (w_issue) begin
      if (!w_i_rowend) begin
        r_icol <= r_icol + c_MBW'(1);
      end else begin
        r_icol <= '0;
        if (!w_i_mbend) begin
          r_irow <= r_irow + c_MBW'(1);
        end else begin
          r_irow <= '0;
          if (!w_i_bend) begin
            r_imb <= r_imb + c_MBX_W'(1);
          end else begin
            r_imb   <= '0;
            r_ibank <= ~r_ibank;
            r_iband <= (r_iband == c_MBY_W'(c_NMBY - 1)) ? '0 : r_iband + c_MBY_W'(1);
          end
        end
      end
    end
  end

  // Stage A tags travel alongside the memory read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_mbx   <= '0;
      r_a_mby   <= '0;
      r_a_first <= 1'b0;
      r_a_last  <= 1'b0;
      r_a_bend  <= 1'b0;
      r_a_fend  <= 1'b0;
    end else if (w_a_ready) begin
      r_a_valid <= w_issue;
      if (w_issue) begin
        r_a_mbx   <= r_imb;
        r_a_mby   <= r_iband;
        r_a_first <= (r_icol == '0) && (r_irow == '0);
        r_a_last  <= w_i_mbend;
        r_a_bend  <= w_i_bend;
        r_a_fend  <= w_i_bend && (r_iband == c_MBY_W'(c_NMBY - 1));
      end
    end
  end

  // Output register: loads from stage A whenever it is empty or being taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_valid <= 1'b0;
      r_b_pix   <= '0;
      r_b_mbx   <= '0;
      r_b_mby   <= '0;
      r_b_first <= 1'b0;
      r_b_last  <= 1'b0;
      r_b_bend  <= 1'b0;
      r_b_fend  <= 1'b0;
    end else if (w_b_ready) begin
      r_b_valid <= r_a_valid;
      if (r_a_valid) begin
        r_b_pix   <= r_a_data;
        r_b_mbx   <= r_a_mbx;
        r_b_mby   <= r_a_mby;
        r_b_first <= r_a_first;
        r_b_last  <= r_a_last;
        r_b_bend  <= r_a_bend;
        r_b_fend  <= r_a_fend;
      end
    end
  end

  assign bus.ready_in  = w_ready_in;
  assign bus.valid_out = r_b_valid;
  assign bus.pixel_out = r_b_pix;
  assign bus.mb_x      = r_b_mbx;
  assign bus.mb_y      = r_b_mby;
  assign bus.first_out = r_b_first;
  assign bus.last_out  = r_b_last;
  assign bus.frame_end = r_b_fend;

endmodule
`default_nettype wire

// File: tb/tb_macroblock_tiler.sv
`default_nettype none
// ============================================================================
// Module      : tb_macroblock_tiler
// Description : Scoreboard bench for macroblock_tiler on a 32x32 frame with
//               4x4 macroblocks. Accepted input bands are tiled by a simple
//               array model into an expected queue that a monitor consumes.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_macroblock_tiler;
  localparam int PW   = 24;
  localparam int FW   = 32;
  localparam int FH   = 32;
  localparam int MB   = 4;
  localparam int NMBX = FW / MB;
  localparam int NMBY = FH / MB;
  localparam int BAND = MB * FW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  macroblock_tiler_if #(.PIXEL_WIDTH(PW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .MB_SIZE(MB)) bus ();

  macroblock_tiler #(.PIXEL_WIDTH(PW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .MB_SIZE(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [PW-1:0] pix;
    int            mbx;
    int            mby;
    bit            first;
    bit            last;
    bit            fend;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // reference model state
  logic [PW-1:0] band [MB][FW];
  int in_cnt   = 0;
  int band_idx = 0;
  int pos      = 0;

  // monitor statistics
  int n_out = 0, n_last = 0, n_fend = 0, fend_at = 0, rec_cnt = 0;
  logic [PW-1:0] rec_pix [16];
  bit rec_first [16];
  bit rec_last  [16];

  // stall / gap tracking
  bit            stalled    = 1'b0;
  logic [PW-1:0] s_pix;
  int            s_mbx, s_mby;
  bit            s_first, s_last, s_fend;
  int            gap_run    = 0;
  bit            after_bend = 1'b1;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor and reference model, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      in_cnt     = 0;
      band_idx   = 0;
      stalled    = 1'b0;
      gap_run    = 0;
      after_bend = 1'b1;
    end else begin
      if (stalled) begin
        tests++;
        if (!bus.valid_out || bus.pixel_out !== s_pix || int'(bus.mb_x) != s_mbx ||
            int'(bus.mb_y) != s_mby || bus.first_out !== s_first ||
            bus.last_out !== s_last || bus.frame_end !== s_fend) begin
          fails++;
          $display("FAIL stall_stable: got v=%0b pix=%0h mbx=%0d expected v=1 pix=%0h mbx=%0d",
                   bus.valid_out, bus.pixel_out, bus.mb_x, s_pix, s_mbx);
        end
      end
      stalled = bus.valid_out && !bus.ready_out;
      s_pix   = bus.pixel_out;
      s_mbx   = int'(bus.mb_x);
      s_mby   = int'(bus.mb_y);
      s_first = bus.first_out;
      s_last  = bus.last_out;
      s_fend  = bus.frame_end;

      if (bus.valid_out && bus.ready_out) begin
        gap_run = 0;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: got pix=%0h expected no output", bus.pixel_out);
        end else begin
          e = q.pop_front();
          if (bus.pixel_out !== e.pix || int'(bus.mb_x) != e.mbx || int'(bus.mb_y) != e.mby ||
              bus.first_out !== e.first || bus.last_out !== e.last || bus.frame_end !== e.fend) begin
            fails++;
            $display("FAIL out_seq: got pix=%0h x=%0d y=%0d f=%0b l=%0b e=%0b expected pix=%0h x=%0d y=%0d f=%0b l=%0b e=%0b",
                     bus.pixel_out, bus.mb_x, bus.mb_y, bus.first_out, bus.last_out, bus.frame_end,
                     e.pix, e.mbx, e.mby, e.first, e.last, e.fend);
          end
          after_bend = e.last && (e.mbx == NMBX - 1);
        end
        n_out++;
        if (bus.last_out) n_last++;
        if (bus.frame_end) begin
          n_fend++;
          fend_at = n_out;
        end
        if (rec_cnt < 16) begin
          rec_pix[rec_cnt]   = bus.pixel_out;
          rec_first[rec_cnt] = bus.first_out;
          rec_last[rec_cnt]  = bus.last_out;
          rec_cnt++;
        end
      end else if (!bus.valid_out && bus.ready_out && q.size() > 0) begin
        gap_run++;
        tests++;
        if (!after_bend || gap_run > 3) begin
          fails++;
          $display("FAIL no_gap: got %0d idle cycles (after band end=%0b) expected 0 mid-band, <=3 at band start",
                   gap_run, after_bend);
        end
      end

      if (bus.valid_in && bus.ready_in) begin
        band[in_cnt / FW][in_cnt % FW] = bus.pixel_in;
        in_cnt++;
        if (in_cnt == BAND) begin
          for (int mc = 0; mc < NMBX; mc++)
            for (int r = 0; r < MB; r++)
              for (int c = 0; c < MB; c++) begin
                e.pix   = band[r][mc * MB + c];
                e.mbx   = mc;
                e.mby   = band_idx;
                e.first = (r == 0) && (c == 0);
                e.last  = (r == MB - 1) && (c == MB - 1);
                e.fend  = e.last && (mc == NMBX - 1) && (band_idx == NMBY - 1);
                q.push_back(e);
              end
          in_cnt   = 0;
          band_idx = (band_idx + 1) % NMBY;
        end
      end
    end
  end

  // Offer pixels until n have been accepted; ramp pixels carry y*FW+x
  task automatic feed(input int n, input int vpct, input int rpct, input bit ramp);
    int done = 0;
    int cyc  = 0;
    while (done < n && cyc < n * 20 + 1000) begin
      @(posedge clk); #1;
      bus.valid_in  = ($urandom_range(99) < vpct);
      bus.pixel_in  = ramp ? PW'(pos) : PW'($urandom);
      bus.ready_out = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (bus.valid_in && bus.ready_in) begin
        done++;
        pos = (pos + 1) % (FW * FH);
      end
      cyc++;
    end
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    if (done < n) chk("feed_timeout", done, n);
  endtask

  // Let the output run until at most `left` expected pixels remain
  task automatic drain_to(input int left, input int rpct);
    int cyc = 0;
    while (q.size() > left && cyc < 20000) begin
      @(posedge clk); #1;
      bus.ready_out = ($urandom_range(99) < rpct);
      @(negedge clk);
      cyc++;
    end
    chk("drain_remaining", (q.size() > left) ? q.size() : left, left);
  endtask

  task automatic clear_stats();
    n_out = 0; n_last = 0; n_fend = 0; fend_at = 0; rec_cnt = 0;
  endtask

  task automatic check_first_mb(input string tag);
    for (int i = 0; i < 16; i++)
      chk({tag, "_pix"}, int'(rec_pix[i]), (i / MB) * FW + (i % MB));
    chk({tag, "_first0"}, int'(rec_first[0]), 1);
    chk({tag, "_first1"}, int'(rec_first[1]), 0);
    chk({tag, "_last15"}, int'(rec_last[15]), 1);
    chk({tag, "_last14"}, int'(rec_last[14]), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid_out"}, int'(bus.valid_out), 0);
    chk({tag, "_ready_in"},  int'(bus.ready_in), 0);
    chk({tag, "_pixel_out"}, int'(bus.pixel_out), 0);
    chk({tag, "_mb_x"},      int'(bus.mb_x), 0);
    chk({tag, "_mb_y"},      int'(bus.mb_y), 0);
    chk({tag, "_first_out"}, int'(bus.first_out), 0);
    chk({tag, "_last_out"},  int'(bus.last_out), 0);
    chk({tag, "_frame_end"}, int'(bus.frame_end), 0);
  endtask

  initial begin
    int extra;
    bus.valid_in  = 1'b0;
    bus.pixel_in  = '0;
    bus.ready_out = 1'b0;

    // reset state
    #22;
    check_reset_outputs("rst");
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("ready_after_release", int'(bus.ready_in), 1);

    // full ramp frame at one pixel per cycle
    clear_stats();
    feed(FW * FH, 100, 100, 1'b1);
    drain_to(0, 100);
    chk("frame_outputs", n_out, FW * FH);
    chk("frame_last_outs", n_last, NMBX * NMBY);
    chk("frame_end_count", n_fend, 1);
    chk("frame_end_index", fend_at, FW * FH);
    check_first_mb("mb0");

    // downstream blocked: two bands fit, then input must stall
    feed(2 * BAND, 100, 0, 1'b1);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.valid_in  = 1'b1;
      bus.pixel_in  = PW'(pos);
      bus.ready_out = 1'b0;
      @(negedge clk);
      if (bus.valid_in && bus.ready_in) begin
        extra++;
        pos = (pos + 1) % (FW * FH);
      end
    end
    chk("stall_ready_in", int'(bus.ready_in), 0);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    chk("no_257th_accept", extra, 0);
    feed(FW * FH - 2 * BAND - extra, 100, 100, 1'b1);
    drain_to(0, 100);

    // random valid/ready over three frames
    feed(3 * FW * FH, 70, 60, 1'b0);
    drain_to(BAND, 100);

    // reset in the middle of a band with output stalled
    feed(70, 100, 0, 1'b1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    pos = 0;
    #1;
    chk("midrst_ready_after_release", int'(bus.ready_in), 1);
    clear_stats();
    feed(FW * FH, 100, 100, 1'b1);
    drain_to(0, 100);
    check_first_mb("post_rst_mb0");
    chk("post_rst_frame_end", n_fend, 1);

    repeat (5) @(negedge clk);
    chk("idle_valid_out", int'(bus.valid_out), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/macroblock_tiler.md
MACROBLOCK_TILER -- requirements
Module: macroblock_tiler

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 24: bits per pixel (packed RGB or YCbCr).
REQ-002 SHALL have parameter FRAME_WIDTH, default 320: pixels per raster line.
REQ-003 SHALL have parameter FRAME_HEIGHT, default 240: lines per frame.
REQ-004 SHALL have parameter MB_SIZE, default 16: macroblock edge in pixels; FRAME_WIDTH and FRAME_HEIGHT multiples of MB_SIZE, elaboration error otherwise.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port valid_in  input  1  pixel_in valid.
REQ-008 SHALL have port ready_in  output  1  block accepts pixel this cycle.
REQ-009 SHALL have port pixel_in  input  PIXEL_WIDTH  raster-order input pixel.
REQ-010 SHALL have port valid_out  output  1  pixel_out valid.
REQ-011 SHALL have port ready_out  input  1  downstream accepts pixel_out.
REQ-012 SHALL have port pixel_out  output  PIXEL_WIDTH  macroblock-order output pixel.
REQ-013 SHALL have port mb_x  output  clog2(FRAME_WIDTH/MB_SIZE)  macroblock column of pixel_out.
REQ-014 SHALL have port mb_y  output  clog2(FRAME_HEIGHT/MB_SIZE)  macroblock row of pixel_out.
REQ-015 SHALL have port first_out  output  1  pixel_out is pixel (0,0) of its macroblock.
REQ-016 SHALL have port last_out  output  1  pixel_out is pixel (MB_SIZE-1,MB_SIZE-1) of its macroblock.
REQ-017 SHALL have port frame_end  output  1  asserted with last_out of the final macroblock of a frame.

Function
REQ-018 SHALL hold two banks (ping-pong), each MB_SIZE x FRAME_WIDTH pixels, addressed row*FRAME_WIDTH+col, 1-cycle read latency, each with a full flag.
REQ-019 SHALL accept an input pixel only on valid_in && ready_in; ready_in = !rst && write bank not full.
REQ-020 SHALL write accepted pixels to the write bank in raster order; after pixel (MB_SIZE-1, FRAME_WIDTH-1) SHALL set that bank full and switch writes to the other bank.
REQ-021 SHALL read a full bank in order: mb column 0..FRAME_WIDTH/MB_SIZE-1, within each macroblock row 0..MB_SIZE-1, within each row column 0..MB_SIZE-1; address r*FRAME_WIDTH + mb_col*MB_SIZE + c.
REQ-022 SHALL clear a bank's full flag in the cycle its last pixel is accepted downstream (valid_out && ready_out && last_out, final mb column) and switch reads to the other bank.
REQ-023 SHALL, when a bank fills and another drains in the same cycle, apply both flag updates with no lost pixel and no bubble.
REQ-024 SHALL register pixel_out/mb_x/mb_y/first_out/last_out/frame_end; while valid_out && !ready_out all SHALL remain stable.
REQ-025 SHALL sustain one output pixel per cycle while ready_out is high and a full bank exists (prefetch/skid so BRAM latency costs no bubble).
REQ-026 SHALL present first pixel of a newly filled band at valid_out no later than 3 cycles after its last input pixel is accepted, given read bank idle and ready_out high.
REQ-027 SHALL increment mb_y per completed band, wrap to 0 after FRAME_HEIGHT/MB_SIZE bands, pulse frame_end exactly with that band's final last_out.
REQ-028 SHALL, with both banks full, hold ready_in low until a bank drains; input pixels SHALL never be dropped or overwritten.

Reset
REQ-029 SHALL, while rst high, force valid_out=0, ready_in=0, pixel_out=0, mb_x=0, mb_y=0, first_out=0, last_out=0, frame_end=0, clear both full flags and all counters.
REQ-030 SHALL, on rst mid-frame, discard partial band and in-flight output; first pixel accepted after rst release is frame pixel (0,0); ready_in=1 the first cycle after release.

Verification
REQ-031 SHALL cover: params 32/32/MB 4, ready_out=1, pixel value = y*32+x -> first MB outputs 0,1,2,3,32,33,34,35,... with first_out on 0, last_out on 99.
REQ-032 SHALL cover: full 32x32 frame at 1 pixel/cycle, ready_out=1 -> 1024 outputs, 64 last_out, one frame_end on the 1024th, mb_y wraps to 0.
REQ-033 SHALL cover: ready_out=0 throughout -> after 2 bands (256 pixels) ready_in=0, no 257th acceptance; ready_out=1 -> outputs resume in order.
REQ-034 SHALL cover: random valid_in/ready_out toggling over 3 frames -> output sequence equals reference tiler model, pixel_out stable under stall.
REQ-035 SHALL cover: rst pulsed at input pixel 70 -> valid_out=0 immediately, next frame from (0,0) produces correct first MB.
REQ-036 SHALL cover: band fill and band drain in the same cycle -> no dropped pixel, no output gap.
